// File: rtl/capture_frame_ctrl.sv
// capture_frame_ctrl: arms on command, aligns to the next frame start and
// turns the assembled camera pixel stream into framebuffer writes, with
// geometry error flags and single-shot / continuous capture modes.
module capture_frame_ctrl #(
    parameter int unsigned H_PIXELS = 320,
    parameter int unsigned V_LINES  = 240,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic                          clk_pixel_in,
    input  logic                          rst_n_in,
    input  logic                          hs_cam_in,
    input  logic                          vs_cam_in,
    input  logic [15:0]                   data_in,
    input  logic                          valid_in,
    input  logic                          start_in,
    input  logic                          stop_in,
    input  logic                          single_in,
    output logic [ADDR_W-1:0]             wr_addr_out,
    output logic [15:0]                   wr_data_out,
    output logic                          wr_en_out,
    output logic [$clog2(H_PIXELS+1)-1:0] hcount_out,
    output logic [$clog2(V_LINES+1)-1:0]  vcount_out,
    output logic                          busy_out,
    output logic                          frame_done_out,
    output logic [7:0]                    frame_count_out,
    output logic [2:0]                    error_out
);

    localparam int unsigned HC_W = $clog2(H_PIXELS + 1);
    localparam int unsigned VC_W = $clog2(V_LINES + 1);
    localparam logic [HC_W-1:0]   H_MAX    = HC_W'(H_PIXELS);
    localparam logic [VC_W-1:0]   V_MAX    = VC_W'(V_LINES);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                vs_prev_q, hs_prev_q;
    logic [HC_W-1:0]     hcount_q, hcount_d, h_tmp;
    logic [VC_W-1:0]     vcount_q, vcount_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic                stop_pending_q, stop_pending_d;
    logic                single_q, single_d;
    logic [2:0]          err_q, err_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                vs_rise, vs_fall, hs_fall;

    assign vs_rise =  vs_cam_in & ~vs_prev_q;
    assign vs_fall = ~vs_cam_in &  vs_prev_q;
    assign hs_fall = ~hs_cam_in &  hs_prev_q;

    // Next state and datapath; within CAPTURE the pixel is applied first,
    // then the line end, then the frame end, so a coincident pixel belongs
    // to the line and frame that are closing.
    always_comb begin
        state_d        = state_q;
        hcount_d       = hcount_q;
        vcount_d       = vcount_q;
        row_base_d     = row_base_q;
        stop_pending_d = stop_pending_q;
        single_d       = single_q;
        err_d          = err_q;
        frame_cnt_d    = frame_cnt_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        done_d         = 1'b0;
        h_tmp          = hcount_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_in && !stop_in) begin
                    state_d        = S_ARM;
                    single_d       = single_in;
                    err_d          = 3'b000;
                    frame_cnt_d    = 8'd0;
                    stop_pending_d = 1'b0;
                end
            end

            S_ARM: begin
                if (stop_in || stop_pending_q) begin
                    state_d        = S_IDLE;
                    stop_pending_d = 1'b0;
                end else if (vs_rise) begin
                    state_d    = S_CAPTURE;
                    hcount_d   = '0;
                    vcount_d   = '0;
                    row_base_d = '0;
                end
            end

            S_CAPTURE: begin
                if (stop_in) begin
                    stop_pending_d = 1'b1;
                end

                if (valid_in) begin
                    if ((hcount_q < H_MAX) && (vcount_q < V_MAX)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = row_base_q + ADDR_W'(hcount_q);
                        wr_data_d = data_in;
                        h_tmp     = hcount_q + HC_W'(1);
                    end else begin
                        if (hcount_q == H_MAX) begin
                            err_d[1] = 1'b1;
                        end
                        // A pixel after the last active line means the frame is too tall.
                        if (vcount_q == V_MAX) begin
                            err_d[2] = 1'b1;
                        end
                    end
                end
                hcount_d = h_tmp;

                if (hs_fall) begin
                    if ((h_tmp != '0) && (h_tmp < H_MAX)) begin
                        err_d[0] = 1'b1;
                    end
                    hcount_d = '0;
                    if ((h_tmp != '0) && (vcount_q < V_MAX)) begin
                        vcount_d   = vcount_q + VC_W'(1);
                        row_base_d = row_base_q + ROW_STEP;
                    end
                end

                if (vs_fall) begin
                    if (vcount_d != V_MAX) begin
                        err_d[2] = 1'b1;
                    end
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (single_q || stop_pending_q || stop_in) begin
                        state_d        = S_IDLE;
                        stop_pending_d = 1'b0;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, edge detectors and registered outputs.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= S_IDLE;
            vs_prev_q      <= 1'b0;
            hs_prev_q      <= 1'b0;
            hcount_q       <= '0;
            vcount_q       <= '0;
            row_base_q     <= '0;
            stop_pending_q <= 1'b0;
            single_q       <= 1'b0;
            err_q          <= 3'b000;
            frame_cnt_q    <= 8'd0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= 16'd0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            vs_prev_q      <= vs_cam_in;
            hs_prev_q      <= hs_cam_in;
            hcount_q       <= hcount_d;
            vcount_q       <= vcount_d;
            row_base_q     <= row_base_d;
            stop_pending_q <= stop_pending_d;
            single_q       <= single_d;
            err_q          <= err_d;
            frame_cnt_q    <= frame_cnt_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            done_q         <= done_d;
        end
    end

    // Output mapping; busy is decoded straight from the state register.
    assign busy_out        = (state_q == S_ARM) || (state_q == S_CAPTURE);
    assign wr_en_out       = wr_en_q;
    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;
    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign frame_done_out  = done_q;
    assign frame_count_out = frame_cnt_q;
    assign error_out       = err_q;

endmodule

// File: tb/tb_capture_frame_ctrl.sv
// Bench for capture_frame_ctrl: a frame/line/pixel-count model predicts every
// output each cycle; literal checks after each scenario pin the model.
module tb_capture_frame_ctrl;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hs, vs, valid, start, stop, single;
    logic [15:0]   data;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_en;
    logic [2:0]    hcount;
    logic [1:0]    vcount;
    logic          busy, frame_done;
    logic [7:0]    frame_count;
    logic [2:0]    error;

    int errors = 0;
    int checks = 0;
    int dcount = 0;

    capture_frame_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk_pixel_in(clk), .rst_n_in(rst_n),
        .hs_cam_in(hs), .vs_cam_in(vs), .data_in(data), .valid_in(valid),
        .start_in(start), .stop_in(stop), .single_in(single),
        .wr_addr_out(wr_addr), .wr_data_out(wr_data), .wr_en_out(wr_en),
        .hcount_out(hcount), .vcount_out(vcount), .busy_out(busy),
        .frame_done_out(frame_done), .frame_count_out(frame_count),
        .error_out(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: phase 0 idle, 1 waiting for frame start, 2 inside a frame.
    int          m_phase, m_line, m_pix, m_frames;
    bit          m_single, m_stop, m_vsp, m_hsp;
    logic [2:0]  m_err;
    logic        e_wen, e_done;
    logic [3:0]  e_addr;
    logic [15:0] e_data;

    always @(posedge clk or negedge rst_n) begin : model
        int ph, ln, px, fr;
        bit sg, sp, vr, vf, hf;
        logic [2:0] er;
        logic wen, dn;
        logic [3:0] ad;
        logic [15:0] dt;
        if (!rst_n) begin
            m_phase <= 0; m_line <= 0; m_pix <= 0; m_frames <= 0;
            m_single <= 0; m_stop <= 0; m_vsp <= 0; m_hsp <= 0;
            m_err <= 3'b000; e_wen <= 0; e_done <= 0; e_addr <= 0; e_data <= 0;
        end else begin
            ph = m_phase; ln = m_line; px = m_pix; fr = m_frames;
            sg = m_single; sp = m_stop; er = m_err;
            wen = 0; dn = 0; ad = e_addr; dt = e_data;
            vr = vs && !m_vsp; vf = !vs && m_vsp; hf = !hs && m_hsp;
            if (ph == 0) begin
                if (start && !stop) begin
                    ph = 1; sg = single; er = 3'b000; fr = 0; sp = 0;
                end
            end else if (ph == 1) begin
                if (stop || sp) begin
                    ph = 0; sp = 0;
                end else if (vr) begin
                    ph = 2; ln = 0; px = 0;
                end
            end else begin
                if (stop) sp = 1;
                if (valid) begin
                    if (ln < V && px < H) begin
                        wen = 1; ad = 4'(ln * H + px); dt = data;
                    end else if (ln < V) begin
                        er[1] = 1;
                    end else begin
                        er[2] = 1;
                    end
                    px++;
                end
                if (hf && px > 0) begin
                    if (ln < V && px < H) er[0] = 1;
                    ln++;
                    px = 0;
                end
                if (vf) begin
                    if (ln != V) er[2] = 1;
                    dn = 1;
                    fr = (fr + 1) % 256;
                    ph = (sg || sp) ? 0 : 1;
                    if (ph == 0) sp = 0;
                end
            end
            m_phase <= ph; m_line <= ln; m_pix <= px; m_frames <= fr;
            m_single <= sg; m_stop <= sp; m_err <= er;
            e_wen <= wen; e_done <= dn; e_addr <= ad; e_data <= dt;
            m_vsp <= vs; m_hsp <= hs;
        end
    end

    // Write log for literal checks, cleared on request from the stimulus.
    bit         log_clr = 0;
    int         wcnt, done_cnt, wfirst;
    bit         wmask [16];
    logic [15:0] wdat [16];

    // Per-cycle comparison against the model, plus write logging.
    always @(negedge clk) begin
        chk("wr_en", int'(wr_en), int'(e_wen));
        if (e_wen) begin
            chk("wr_addr", int'(wr_addr), int'(e_addr));
            chk("wr_data", int'(wr_data), int'(e_data));
        end
        chk("frame_done", int'(frame_done), int'(e_done));
        chk("frame_count", int'(frame_count), m_frames);
        chk("error", int'(error), int'(m_err));
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("hcount", int'(hcount), (m_line < V) ? ((m_pix < H) ? m_pix : H) : 0);
        chk("vcount", int'(vcount), (m_line < V) ? m_line : V);
        if (log_clr) begin
            wcnt = 0; done_cnt = 0; wfirst = -1;
            for (int i = 0; i < 16; i++) begin
                wmask[i] = 0; wdat[i] = 16'hFFFF;
            end
        end else begin
            if (wr_en) begin
                if (wcnt == 0) wfirst = int'(wr_addr);
                wcnt++;
                wmask[wr_addr] = 1;
                wdat[wr_addr]  = wr_data;
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_clr = 1; cyc(); log_clr = 0;
    endtask

    task automatic start_cap(input bit sgl);
        single = sgl; start = 1; cyc(); start = 0; cyc();
    endtask

    task automatic do_frame(input int nl, input int c0, input int c1, input int c2,
                            input int c3, input int stop_ln);
        int c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        vs = 1; cyc(); cyc();
        for (int l = 0; l < nl; l++) begin
            hs = 1; cyc();
            for (int p = 0; p < c[l]; p++) begin
                valid = 1; data = 16'(dcount); dcount++;
                if (l == stop_ln && p == 0) stop = 1;
                cyc();
                valid = 0; stop = 0; cyc();
            end
            hs = 0; cyc(); cyc();
        end
        vs = 0; cyc(); cyc(); cyc();
    endtask

    initial begin
        rst_n = 0; hs = 0; vs = 0; valid = 0; start = 0; stop = 0; single = 0; data = 0;
        cyc(); cyc(); cyc();
        chk("reset wr_en", int'(wr_en), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_count", int'(frame_count), 0);
        chk("reset error", int'(error), 0);
        rst_n = 1; cyc();

        // Single frame, 3 lines x 4 pixels, data 0..11.
        clear_log(); dcount = 0;
        start_cap(1);
        do_frame(3, 4, 4, 4, 0, -1);
        chk("single wcnt", wcnt, 12);
        for (int a = 0; a < 12; a++) begin
            chk("single mask", int'(wmask[a]), 1);
            chk("single data", int'(wdat[a]), a);
        end
        chk("single done_cnt", done_cnt, 1);
        chk("single frame_count", int'(frame_count), 1);
        chk("single error", int'(error), 0);
        chk("single busy", int'(busy), 0);

        // Arm while a frame is already running.
        clear_log();
        vs = 1; hs = 1; cyc();
        for (int p = 0; p < 4; p++) begin
            valid = 1; data = 16'(100 + p);
            if (p == 1) begin single = 1; start = 1; end
            cyc(); valid = 0; start = 0; cyc();
        end
        hs = 0; cyc(); cyc(); vs = 0; cyc(); cyc();
        chk("midarm wcnt before", wcnt, 0);
        chk("midarm busy", int'(busy), 1);
        dcount = 0;
        do_frame(3, 4, 4, 4, 0, -1);
        chk("midarm first addr", wfirst, 0);
        chk("midarm wcnt", wcnt, 12);
        chk("midarm frame_count", int'(frame_count), 1);

        // Short middle line keeps row alignment.
        clear_log();
        start_cap(1);
        do_frame(3, 4, 3, 4, 0, -1);
        chk("short error", int'(error), 1);
        chk("short wcnt", wcnt, 11);
        chk("short addr7", int'(wmask[7]), 0);
        for (int a = 8; a < 12; a++) chk("short row2", int'(wmask[a]), 1);

        // Long first line and one extra line.
        clear_log();
        start_cap(1);
        do_frame(4, 6, 4, 4, 4, -1);
        chk("long error", int'(error), 6);
        chk("long wcnt", wcnt, 12);
        chk("long addr4 once", int'(wmask[4]), 1);

        // Continuous mode, stop during the second frame.
        clear_log();
        start_cap(0);
        do_frame(3, 4, 4, 4, 0, -1);
        chk("cont busy after f1", int'(busy), 1);
        do_frame(3, 4, 4, 4, 0, 1);
        chk("cont frame_count", int'(frame_count), 2);
        chk("cont busy", int'(busy), 0);
        do_frame(3, 4, 4, 4, 0, -1);
        chk("cont wcnt", wcnt, 24);
        chk("cont done_cnt", done_cnt, 2);

        // Asynchronous reset during line 1.
        clear_log();
        start_cap(1);
        vs = 1; cyc(); cyc();
        hs = 1; cyc();
        for (int p = 0; p < 4; p++) begin valid = 1; cyc(); valid = 0; cyc(); end
        hs = 0; cyc(); cyc(); hs = 1; cyc();
        for (int p = 0; p < 2; p++) begin valid = 1; cyc(); valid = 0; cyc(); end
        #3 rst_n = 0;
        #1;
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst hcount", int'(hcount), 0);
        chk("rst vcount", int'(vcount), 0);
        chk("rst frame_count", int'(frame_count), 0);
        valid = 1; cyc(); valid = 0;
        @(posedge clk); #1 rst_n = 1;
        clear_log();
        for (int p = 0; p < 2; p++) begin valid = 1; cyc(); valid = 0; cyc(); end
        hs = 0; cyc(); vs = 0; cyc(); cyc();
        do_frame(3, 4, 4, 4, 0, -1);
        chk("rst no writes", wcnt, 0);
        chk("rst idle", int'(busy), 0);

        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/capture_frame_ctrl.md
Name: capture_frame_ctrl

Overview:
- Sequences frame capture from the camera byte-assembly stage into a framebuffer write port.
- Arms on command and aligns to the next frame start (rising vs_cam_in).
- Tracks pixel column and line position and generates framebuffer write address, data and enable.
- Drops out-of-bounds pixels, flags geometry errors, and runs in single-shot or continuous mode with graceful stop.

Parameters:
H_PIXELS, 320, active pixels per line
V_LINES, 240, active lines per frame
ADDR_W, 17, framebuffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES

Ports:
clk_pixel_in  input  1  system pixel clock; all logic on rising edge
rst_n_in  input  1  asynchronous active-low reset
hs_cam_in  input  1  registered line-active from capture stage (high during active line)
vs_cam_in  input  1  registered frame-active from capture stage (high during active frame)
data_in  input  16  assembled pixel
valid_in  input  1  one-cycle strobe: data_in holds a complete pixel
start_in  input  1  pulse: arm capture (honoured only in IDLE)
stop_in  input  1  pulse: request stop after current frame
single_in  input  1  sampled at start_in: 1 = one frame, 0 = continuous
wr_addr_out  output  ADDR_W  framebuffer write address
wr_data_out  output  16  framebuffer write data
wr_en_out  output  1  framebuffer write strobe
hcount_out  output  $clog2(H_PIXELS+1)  current column
vcount_out  output  $clog2(V_LINES+1)  current line
busy_out  output  1  high in ARM or CAPTURE
frame_done_out  output  1  one-cycle pulse at end of each captured frame
frame_count_out  output  8  completed frames since start_in; wraps 255->0
error_out  output  3  sticky: [0] short line, [1] long line, [2] line count mismatch

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - State goes to IDLE.
  - All outputs, counters, row base, stop_pending, mode and edge-detect registers go to 0.
  - Release mid-capture resumes in IDLE; no writes occur until a new start_in.
- Edge detection: vs_prev and hs_prev are registered every cycle.
  - vs rise = vs_cam_in & ~vs_prev.
  - vs fall = ~vs_cam_in & vs_prev.
  - hs fall = ~hs_cam_in & hs_prev.
- States:
  - IDLE:
    - start_in & ~stop_in -> ARM.
    - Latches single_in.
    - Clears error_out, frame_count_out and stop_pending.
    - start_in & stop_in together: start ignored.
  - ARM:
    - vs rise -> CAPTURE; hcount, vcount and row_base cleared.
    - stop_in or stop_pending -> IDLE.
    - Starting mid-frame (vs already high) waits for the next rising edge; no writes meanwhile.
  - CAPTURE, pixel acceptance:
    - valid_in accepted regardless of hs level.
    - If hcount < H_PIXELS and vcount < V_LINES: wr_en_out=1, wr_addr_out=row_base+hcount, wr_data_out=data_in (1-cycle latency), then hcount++.
    - Otherwise: pixel dropped (wr_en_out=0); if hcount == H_PIXELS, set error_out[1].
    - hcount saturates at H_PIXELS.
  - CAPTURE, hs fall:
    - If 0 < hcount < H_PIXELS, set error_out[0].
    - hcount = 0.
    - If vcount < V_LINES: vcount++ and row_base += H_PIXELS.
    - hs fall with hcount == 0 (no pixels on the line) is not counted as a line.
  - CAPTURE, vs fall:
    - If vcount != V_LINES, set error_out[2].
    - frame_done_out=1 for one cycle; frame_count_out++.
    - Next state: IDLE if mode single or stop_pending (or stop_in this cycle), else ARM.
- stop_in in CAPTURE sets stop_pending; the frame completes normally.
- Same-cycle ordering within CAPTURE: pixel acceptance first, then hs fall, then vs fall.
  - A valid_in coinciding with hs fall belongs to the ending line.
  - A valid_in coinciding with vs fall is written before the frame closes.
- Write strobe: wr_en_out is high only for single cycles following accepted pixels, never outside CAPTURE.
- busy_out is combinational from state.
- hcount_out and vcount_out are the live counters.

Test Plan (H_PIXELS=4, V_LINES=3, ADDR_W=4):
- Single-frame capture:
  - Stimulus: start_in with single_in=1; vs rise; 3 lines x 4 valid pixels (data 0x0000..0x000B); vs fall.
  - Response: wr_addr 0..11 matching data; frame_done pulse once; frame_count_out=1; error_out=0; IDLE.
- Arm mid-frame:
  - Stimulus: start_in while vs high with pixels streaming.
  - Response: no wr_en until after the next vs rise; first write has addr 0.
- Short line:
  - Stimulus: line 1 has 3 pixels.
  - Response: error_out=3'b001; line 2 addresses are 8..11 (row alignment kept); no write to addr 7.
- Long line and extra lines:
  - Stimulus: line 0 has 6 pixels; frame has 4 lines.
  - Response: writes addr 0..3 only for line 0; lines beyond 3 dropped; error_out=3'b110.
- Continuous with stop:
  - Stimulus: single_in=0; two frames; stop_in mid-second frame.
  - Response: second frame completes; frame_count_out=2; returns to IDLE; a third vs rise produces no writes.
- Reset mid-capture:
  - Stimulus: rst_n_in low during line 1 of a frame.
  - Response: outputs 0 immediately (asynchronous); after release, state IDLE and no writes on subsequent pixels.
